// File: rtl/pipe_skid_stage.sv
// Pipeline-boundary register with a 2-entry skid buffer, flush, bubble marking,
// sticky halt and saturating bubble/stall counters. in_ready is purely registered.
module pipe_skid_stage #(
    parameter int PAYLOAD_W      = 80,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int HALT_EN        = 1,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_nop,
    input  logic                 in_halt,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_nop,
    output logic                 out_halt,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic                 halted,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   halted_q, halted_d;
    logic                   main_nop_q, main_halt_q;
    logic [PAYLOAD_W-1:0]   main_pl_q;
    logic                   skid_nop_q, skid_halt_q;
    logic [PAYLOAD_W-1:0]   skid_pl_q;
    logic [CNT_W-1:0]       bubble_cnt_q, stall_cnt_q;

    logic in_fire, out_fire, in_halt_eff;
    logic load_main_in, load_main_skid, load_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign in_ready    = (state_q != FULL) && !halted_q;
    assign out_valid   = (state_q != EMPTY);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign in_halt_eff = (HALT_EN != 0) && in_halt;

    assign out_nop     = out_valid ? main_nop_q : 1'b1;
    assign out_halt    = out_valid && main_halt_q;
    assign out_payload = main_pl_q;
    assign occupancy   = state_q;
    assign halted      = halted_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        state_d        = state_q;
        halted_d       = halted_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            halted_d = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid always drains ahead of newer entries to keep FIFO order.
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (in_fire && in_halt_eff) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_nop_q  <= 1'b0;
            main_halt_q <= 1'b0;
            main_pl_q   <= '0;
            skid_nop_q  <= 1'b0;
            skid_halt_q <= 1'b0;
            skid_pl_q   <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH != 0) begin
                main_halt_q <= 1'b0;
                main_pl_q   <= '0;
                skid_halt_q <= 1'b0;
                skid_pl_q   <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_nop_q  <= in_nop;
                main_halt_q <= in_halt_eff;
                main_pl_q   <= in_payload;
            end else if (load_main_skid) begin
                main_nop_q  <= skid_nop_q;
                main_halt_q <= skid_halt_q;
                main_pl_q   <= skid_pl_q;
            end
            if (load_skid) begin
                skid_nop_q  <= in_nop;
                skid_halt_q <= in_halt_eff;
                skid_pl_q   <= in_payload;
            end
        end
    end

    // Counters see the pre-flush state and survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (!out_valid && !halted_q) bubble_cnt_q <= sat_inc(bubble_cnt_q);
            if (out_valid && !out_ready) stall_cnt_q  <= sat_inc(stall_cnt_q);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised and directed bench for pipe_skid_stage: a queue-based reference
// model predicts handshake/state, and a separate monitor checks every output entry.
module tb_pipe_skid_stage;

    localparam int PW   = 80;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          nop;
        logic          halt;
        logic [PW-1:0] pl;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_nop = 1'b0;
    logic          in_halt = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_nop;
    logic          out_halt;
    logic [PW-1:0] out_payload;
    logic [1:0]    occupancy;
    logic          halted;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] stall_cnt;

    pipe_skid_stage #(
        .PAYLOAD_W(PW), .CLEAR_ON_FLUSH(1), .HALT_EN(1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
        .in_halt(in_halt), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_nop(out_nop),
        .out_halt(out_halt), .out_payload(out_payload),
        .occupancy(occupancy), .halted(halted),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds exactly the entries the stage should hold.
    ent_t exp_q[$];
    bit   m_halted = 1'b0;
    int   m_bub = 0;
    int   m_stall = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // One clock: check model state at negedge, drive inputs, advance model.
    task automatic cycle(input logic v, input logic nop, input logic hlt,
                         input logic [PW-1:0] pl, input logic ordy, input logic fl);
        bit rdy;
        @(negedge clk);
        rdy = (exp_q.size() < 2) && !m_halted;
        chk("in_ready", PW'(in_ready), PW'(rdy));
        chk("occupancy", PW'(occupancy), PW'(exp_q.size()));
        chk("out_valid", PW'(out_valid), PW'(exp_q.size() != 0));
        chk("halted", PW'(halted), PW'(m_halted));
        chk("bubble_cnt", PW'(bubble_cnt), PW'(m_bub));
        chk("stall_cnt", PW'(stall_cnt), PW'(m_stall));
        if (exp_q.size() == 0) begin
            chk("idle_out_nop", PW'(out_nop), PW'(1'b1));
            chk("idle_out_halt", PW'(out_halt), PW'(1'b0));
        end
        in_valid = v; in_nop = nop; in_halt = hlt; in_payload = pl;
        out_ready = ordy; flush = fl;
        #1;
        if (exp_q.size() == 0 && !m_halted && m_bub < CMAX) m_bub++;
        if (exp_q.size() != 0 && !ordy && m_stall < CMAX) m_stall++;
        if (fl) m_halted = 1'b0;
        else if (v && rdy) begin
            exp_q.push_back('{nop: nop, halt: hlt, pl: pl});
            if (hlt) m_halted = 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, ordy, 1'b0);
    endtask

    // Monitor: pops the expected entry whenever the DUT completes an output transfer.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %0h expected none", out_payload);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_payload", out_payload, e.pl);
                    chk("out_nop", PW'(out_nop), PW'(e.nop));
                    chk("out_halt", PW'(out_halt), PW'(e.halt));
                end
            end
            if (flush) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] rp;
        #7;
        chk("rst_out_valid", PW'(out_valid), PW'(1'b0));
        chk("rst_out_nop", PW'(out_nop), PW'(1'b1));
        chk("rst_in_ready", PW'(in_ready), PW'(1'b1));
        chk("rst_payload", out_payload, '0);
        #1 rst_n = 1'b1;

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, PW'(i), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-pressure: A, B fill both entries, C held off until space frees
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hA), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hB), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hC), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hC), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hC), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hC), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Flush while FULL with 0xD offered
        cycle(1'b1, 1'b1, 1'b0, PW'(32'h1E), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'h1F), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, PW'(32'hD), 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("flush_payload", out_payload, '0);
        chk("flush_out_halt", PW'(out_halt), PW'(1'b0));
        idle(1, 1'b1);

        // Halt: 0x12 must never be accepted
        cycle(1'b1, 1'b0, 1'b0, PW'(32'h10), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, PW'(32'h11), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, PW'(32'h12), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Bubble counter saturation, then flush must not clear it
        idle((1 << CW) + 5, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("bubble_sat", PW'(bubble_cnt), PW'(CMAX));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rp = PW'({$urandom(), $urandom(), $urandom()});
            cycle(1'(($urandom_range(0, 9)) < 7), 1'(($urandom_range(0, 4)) == 0),
                  1'(($urandom_range(0, 29)) == 0), rp,
                  1'(($urandom_range(0, 9)) < 6), 1'(($urandom_range(0, 29)) == 0));
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Async reset while FULL and halted
        cycle(1'b1, 1'b0, 1'b0, PW'(32'h21), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, PW'(32'h22), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", PW'(out_valid), PW'(1'b0));
        chk("arst_out_nop", PW'(out_nop), PW'(1'b1));
        chk("arst_out_halt", PW'(out_halt), PW'(1'b0));
        chk("arst_payload", out_payload, '0);
        chk("arst_occupancy", PW'(occupancy), PW'(0));
        chk("arst_halted", PW'(halted), PW'(1'b0));
        chk("arst_in_ready", PW'(in_ready), PW'(1'b1));
        chk("arst_bubble", PW'(bubble_cnt), PW'(0));
        chk("arst_stall", PW'(stall_cnt), PW'(0));
        exp_q.delete();
        m_halted = 1'b0;
        m_stall = 0;
        // The edge right after release is an idle, unhalted cycle.
        m_bub = 1;
        #1 rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, PW'(32'h55), 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
